// File: rtl/meter_pkg.sv
// Shared types and constants for the meter frame transmitter and its capture buffer.
package meter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND     = 3'd1,
        ST_GUARD    = 3'd2,
        ST_WAIT_RDY = 3'd3,
        ST_DONE     = 3'd4
    } fsm_state_e;

    localparam int FRAME_LEN = 15;
    localparam logic [7:0] SYNC0_DEF = 8'hA5;
    localparam logic [7:0] SYNC1_DEF = 8'h5A;

    localparam int V_W = 22;
    localparam int I_W = 22;
    localparam int P_W = 36;
    localparam int VI_FRAME_W = 24;
    localparam int P_FRAME_W  = 40;

    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/meter_sample_buf.sv
// Active/pending sample capture for the frame transmitter; the active set only changes
// when it is free (idle) or being released at the end of a frame.
module meter_sample_buf
    import meter_pkg::*;
(
    input  logic           clk100,
    input  logic           rst_p,
    input  logic           sample_valid,
    input  logic [V_W-1:0] data_v,
    input  logic [I_W-1:0] data_i,
    input  logic [P_W-1:0] data_p,
    input  logic           release_act,
    output logic [V_W-1:0] act_v,
    output logic [I_W-1:0] act_i,
    output logic [P_W-1:0] act_p,
    output logic           act_loaded,
    output logic           pend_full,
    output logic           pend_full_nxt,
    output logic [7:0]     drop_count
);

    logic [V_W-1:0] act_v_q, act_v_d, pend_v_q, pend_v_d;
    logic [I_W-1:0] act_i_q, act_i_d, pend_i_q, pend_i_d;
    logic [P_W-1:0] act_p_q, act_p_d, pend_p_q, pend_p_d;
    logic           act_loaded_q, act_loaded_d;
    logic           pend_full_q, pend_full_d;
    logic [7:0]     drop_q, drop_d;
    logic           free_s;

    // Capture, promote and overrun accounting for the two sample slots.
    always_comb begin
        act_v_d      = act_v_q;
        act_i_d      = act_i_q;
        act_p_d      = act_p_q;
        act_loaded_d = act_loaded_q;
        pend_v_d     = pend_v_q;
        pend_i_d     = pend_i_q;
        pend_p_d     = pend_p_q;
        pend_full_d  = pend_full_q;
        drop_d       = drop_q;
        free_s       = !act_loaded_q || release_act;
        if (free_s) begin
            if (pend_full_q) begin
                // Promote first; a coincident sample refills the emptied slot without a drop.
                act_v_d      = pend_v_q;
                act_i_d      = pend_i_q;
                act_p_d      = pend_p_q;
                act_loaded_d = 1'b1;
                pend_full_d  = sample_valid;
                pend_v_d     = sample_valid ? data_v : pend_v_q;
                pend_i_d     = sample_valid ? data_i : pend_i_q;
                pend_p_d     = sample_valid ? data_p : pend_p_q;
            end else if (sample_valid) begin
                act_v_d      = data_v;
                act_i_d      = data_i;
                act_p_d      = data_p;
                act_loaded_d = 1'b1;
            end else begin
                act_loaded_d = 1'b0;
            end
        end else if (sample_valid) begin
            pend_v_d    = data_v;
            pend_i_d    = data_i;
            pend_p_d    = data_p;
            pend_full_d = 1'b1;
            if (pend_full_q && (drop_q != 8'hFF)) begin
                drop_d = drop_q + 8'd1;
            end else begin
                drop_d = drop_q;
            end
        end else begin
            act_loaded_d = act_loaded_q;
        end
    end

    // Slot registers.
    always_ff @(posedge clk100 or posedge rst_p) begin
        if (rst_p) begin
            act_v_q      <= '0;
            act_i_q      <= '0;
            act_p_q      <= '0;
            act_loaded_q <= 1'b0;
            pend_v_q     <= '0;
            pend_i_q     <= '0;
            pend_p_q     <= '0;
            pend_full_q  <= 1'b0;
            drop_q       <= 8'd0;
        end else begin
            act_v_q      <= act_v_d;
            act_i_q      <= act_i_d;
            act_p_q      <= act_p_d;
            act_loaded_q <= act_loaded_d;
            pend_v_q     <= pend_v_d;
            pend_i_q     <= pend_i_d;
            pend_p_q     <= pend_p_d;
            pend_full_q  <= pend_full_d;
            drop_q       <= drop_d;
        end
    end

    assign act_v         = act_v_q;
    assign act_i         = act_i_q;
    assign act_p         = act_p_q;
    assign act_loaded    = act_loaded_q;
    assign pend_full     = pend_full_q;
    assign pend_full_nxt = pend_full_d;
    assign drop_count    = drop_q;

endmodule

// File: rtl/meter_frame_tx.sv
// Serialises captured V/I/P measurements as 15-byte sync/sequence/checksum frames
// over the UART byte handshake.
module meter_frame_tx
    import meter_pkg::*;
#(
    parameter logic [7:0] SYNC0     = SYNC0_DEF,
    parameter logic [7:0] SYNC1     = SYNC1_DEF,
    parameter int         GUARD_CYC = 2
) (
    input  logic           clk100,
    input  logic           rst_p,
    input  logic           sample_valid,
    input  logic [V_W-1:0] data_v,
    input  logic [I_W-1:0] data_i,
    input  logic [P_W-1:0] data_p,
    input  logic           tx_ready,
    output logic           tx_en,
    output logic [7:0]     tx_byte,
    output logic           busy,
    output logic           frame_done,
    output logic [7:0]     drop_count
);

    localparam logic [3:0] GUARD_LAST = 4'(GUARD_CYC - 1);
    localparam logic [3:0] LAST_IDX   = 4'(FRAME_LEN - 1);

    fsm_state_e state_q, state_d;
    logic [3:0] idx_q, idx_d, guard_q, guard_d;
    logic [7:0] seq_q, seq_d, csum_q, csum_d, tx_byte_q, tx_byte_d;
    logic       tx_en_q, tx_en_d, frame_done_q, frame_done_d, busy_q, busy_d;
    logic       release_s, act_loaded_s, pend_full_s, pend_full_nxt_s;
    logic [V_W-1:0]        act_v_s;
    logic [I_W-1:0]        act_i_s;
    logic [P_W-1:0]        act_p_s;
    logic [VI_FRAME_W-1:0] v_w_s, i_w_s;
    logic [P_FRAME_W-1:0]  p_w_s;
    logic [7:0]            cur_byte_s;

    meter_sample_buf u_buf (
        .clk100        (clk100),
        .rst_p         (rst_p),
        .sample_valid  (sample_valid),
        .data_v        (data_v),
        .data_i        (data_i),
        .data_p        (data_p),
        .release_act   (release_s),
        .act_v         (act_v_s),
        .act_i         (act_i_s),
        .act_p         (act_p_s),
        .act_loaded    (act_loaded_s),
        .pend_full     (pend_full_s),
        .pend_full_nxt (pend_full_nxt_s),
        .drop_count    (drop_count)
    );

    assign v_w_s = {{(VI_FRAME_W - V_W){act_v_s[V_W-1]}}, act_v_s};
    assign i_w_s = {{(VI_FRAME_W - I_W){act_i_s[I_W-1]}}, act_i_s};
    assign p_w_s = {{(P_FRAME_W - P_W){act_p_s[P_W-1]}}, act_p_s};

    function automatic logic [7:0] frame_byte(
        input logic [3:0]            idx,
        input logic [7:0]            seq,
        input logic [7:0]            csum,
        input logic [VI_FRAME_W-1:0] v,
        input logic [VI_FRAME_W-1:0] i,
        input logic [P_FRAME_W-1:0]  p
    );
        case (idx)
            4'd0:    return SYNC0;
            4'd1:    return SYNC1;
            4'd2:    return seq;
            4'd3:    return v[23:16];
            4'd4:    return v[15:8];
            4'd5:    return v[7:0];
            4'd6:    return i[23:16];
            4'd7:    return i[15:8];
            4'd8:    return i[7:0];
            4'd9:    return p[39:32];
            4'd10:   return p[31:24];
            4'd11:   return p[23:16];
            4'd12:   return p[15:8];
            4'd13:   return p[7:0];
            4'd14:   return csum;
            default: return 8'h00;
        endcase
    endfunction

    // Byte currently addressed by the frame index.
    always_comb begin
        cur_byte_s = frame_byte(idx_q, seq_q, csum_q, v_w_s, i_w_s, p_w_s);
    end

    // Frame sequencing: next state, strobes and running checksum.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        guard_d      = guard_q;
        seq_d        = seq_q;
        csum_d       = csum_q;
        tx_en_d      = 1'b0;
        tx_byte_d    = tx_byte_q;
        frame_done_d = 1'b0;
        release_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (act_loaded_s) begin
                    idx_d   = 4'd0;
                    csum_d  = 8'd0;
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (tx_ready) begin
                    tx_en_d   = 1'b1;
                    tx_byte_d = cur_byte_s;
                    // Sync bytes and the checksum itself stay out of the sum.
                    if ((idx_q >= 4'd2) && (idx_q <= 4'd13)) begin
                        csum_d = csum_add(csum_q, cur_byte_s);
                    end else begin
                        csum_d = csum_q;
                    end
                    guard_d = 4'd0;
                    state_d = ST_GUARD;
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_GUARD: begin
                if (guard_q == GUARD_LAST) begin
                    state_d = ST_WAIT_RDY;
                end else begin
                    guard_d = guard_q + 4'd1;
                end
            end
            ST_WAIT_RDY: begin
                if (tx_ready) begin
                    if (idx_q == LAST_IDX) begin
                        frame_done_d = 1'b1;
                        seq_d        = seq_q + 8'd1;
                        state_d      = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = ST_SEND;
                    end
                end else begin
                    state_d = ST_WAIT_RDY;
                end
            end
            ST_DONE: begin
                release_s = 1'b1;
                if (pend_full_s) begin
                    idx_d   = 4'd0;
                    csum_d  = 8'd0;
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE) || pend_full_nxt_s;
    end

    // State and output registers.
    always_ff @(posedge clk100 or posedge rst_p) begin
        if (rst_p) begin
            state_q      <= ST_IDLE;
            idx_q        <= 4'd0;
            guard_q      <= 4'd0;
            seq_q        <= 8'd0;
            csum_q       <= 8'd0;
            tx_en_q      <= 1'b0;
            tx_byte_q    <= 8'd0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            guard_q      <= guard_d;
            seq_q        <= seq_d;
            csum_q       <= csum_d;
            tx_en_q      <= tx_en_d;
            tx_byte_q    <= tx_byte_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    assign tx_en      = tx_en_q;
    assign tx_byte    = tx_byte_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule
